// File: rtl/sodor5_pkg.sv
// Shared encodings, constants and instruction decode for the sodor5 five-stage core.
package sodor5_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SRL = 4'd3, ALU_SRA = 4'd4,
    ALU_AND = 4'd5, ALU_OR = 4'd6, ALU_XOR = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9,
    ALU_COPY2 = 4'd10
  } alu_fun_t;

  typedef enum logic [2:0] {
    MT_NONE = 3'd0, MT_B = 3'd1, MT_H = 3'd2, MT_W = 3'd3, MT_BU = 3'd5, MT_HU = 3'd6
  } mem_typ_t;

  typedef enum logic [1:0] {OP2_RS2, OP2_IMM, OP2_FOUR} op2_sel_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        op1_pc;
    op2_sel_t    op2_sel;
    alu_fun_t    alu_fun;
    logic [31:0] imm;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
    logic        mem_fcn;
    mem_typ_t    mem_typ;
  } ctrl_t;

  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:25], inst[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] inst);
    return {inst[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  function automatic alu_fun_t alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Unsupported encodings fall through with rd=0 and no side effects, i.e. a NOP.
  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t      c;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    c = '0;
    c.alu_fun = ALU_ADD;
    c.mem_typ = MT_NONE;
    c.op2_sel = OP2_IMM;
    c.imm     = imm_i(inst);
    case (inst[6:0])
      OPC_LUI: begin
        c.rd = inst[11:7]; c.alu_fun = ALU_COPY2; c.imm = imm_u(inst);
      end
      OPC_AUIPC: begin
        c.rd = inst[11:7]; c.op1_pc = 1'b1; c.imm = imm_u(inst);
      end
      OPC_JAL: begin
        c.rd = inst[11:7]; c.op1_pc = 1'b1; c.op2_sel = OP2_FOUR;
        c.is_jal = 1'b1; c.imm = imm_j(inst);
      end
      OPC_JALR: if (f3 == 3'd0) begin
        c.rd = inst[11:7]; c.uses_rs1 = 1'b1; c.op1_pc = 1'b1;
        c.op2_sel = OP2_FOUR; c.is_jalr = 1'b1;
      end
      OPC_BRANCH: if (f3 != 3'd2 && f3 != 3'd3) begin
        c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.is_br = 1'b1;
        c.alu_fun = ALU_SUB; c.imm = imm_b(inst);
      end
      OPC_LOAD: if (f3 != 3'd3 && f3 < 3'd6) begin
        c.rd = inst[11:7]; c.uses_rs1 = 1'b1; c.is_load = 1'b1;
        c.mem_typ = mem_typ_t'(f3 + 3'd1);
      end
      OPC_STORE: if (f3 < 3'd3) begin
        c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.is_store = 1'b1; c.mem_fcn = 1'b1;
        c.imm = imm_s(inst); c.mem_typ = mem_typ_t'(f3 + 3'd1);
      end
      OPC_OPIMM: if ((f3 != 3'd1 || f7 == 7'h00) &&
                     (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20)) begin
        c.rd = inst[11:7]; c.uses_rs1 = 1'b1;
        c.alu_fun = alu_of(f3, inst[30] && f3 == 3'd5);
      end
      OPC_OP: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        c.rd = inst[11:7]; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1;
        c.op2_sel = OP2_RS2; c.alu_fun = alu_of(f3, inst[30]);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/sodor5_alu.sv
// Combinational 32-bit RV32I ALU selected by alu_fun.
module sodor5_alu
  import sodor5_pkg::*;
(
  input  alu_fun_t           alu_fun,
  input  logic signed [31:0] op1,
  input  logic signed [31:0] op2,
  output logic signed [31:0] result
);

  logic [4:0] shamt;
  assign shamt = op2[4:0];

  always_comb begin
    result = op1 + op2;
    case (alu_fun)
      ALU_SUB:   result = op1 - op2;
      ALU_SLL:   result = op1 << shamt;
      ALU_SRL:   result = $signed($unsigned(op1) >> shamt);
      ALU_SRA:   result = op1 >>> shamt;
      ALU_AND:   result = op1 & op2;
      ALU_OR:    result = op1 | op2;
      ALU_XOR:   result = op1 ^ op2;
      ALU_SLT:   result = {31'b0, op1 < op2};
      ALU_SLTU:  result = {31'b0, $unsigned(op1) < $unsigned(op2)};
      ALU_COPY2: result = op2;
      default:   result = op1 + op2;
    endcase
  end

endmodule

// File: rtl/sodor5_core.sv
// Five-stage in-order RV32I core with a single-entry load buffer in place of data memory.
module sodor5_core
  import sodor5_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   fe_in_io_imem_resp_bits_data,
  output logic [31:0]   fe_ou_io_imem_req_bits_addr,
  output logic          fe_ou_io_imem_req_valid,
  output logic [1023:0] port_regfile,
  output logic [31:0]   port_if_reg_pc,
  output logic [31:0]   port_dec_reg_pc,
  output logic [31:0]   port_exe_reg_pc,
  output logic [31:0]   port_mem_reg_pc,
  output logic [31:0]   port_dec_reg_inst,
  output logic [31:0]   port_exe_reg_inst,
  output logic [31:0]   port_mem_reg_inst,
  output logic [31:0]   port_imm,
  output logic [31:0]   port_imm_sbtype_sext,
  output logic [4:0]    port_reg_rs1_addr_in,
  output logic [4:0]    port_reg_rs2_addr_in,
  output logic [31:0]   port_reg_rs1_data_out,
  output logic [31:0]   port_reg_rs2_data_out,
  output logic [4:0]    port_reg_rd_addr_in,
  output logic [31:0]   port_reg_rd_data_in,
  output logic [4:0]    port_dec_wbaddr,
  output logic [4:0]    port_exe_reg_wbaddr,
  output logic [4:0]    port_mem_reg_wbaddr,
  output logic [31:0]   port_alu_out,
  output logic [31:0]   port_mem_reg_alu_out,
  output logic [3:0]    port_alu_fun,
  output logic          port_mem_fcn,
  output logic [2:0]    port_mem_typ,
  output logic          port_lb_table_valid,
  output logic [31:0]   port_lb_table_addr,
  output logic [31:0]   port_lb_table_data
);

  function automatic logic [31:0] load_ext(input mem_typ_t t, input logic [31:0] w);
    case (t)
      MT_B:    return {{24{w[7]}}, w[7:0]};
      MT_H:    return {{16{w[15]}}, w[15:0]};
      MT_BU:   return {24'b0, w[7:0]};
      MT_HU:   return {16'b0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(input mem_typ_t t);
    case (t)
      MT_B:    return 32'h0000_00FF;
      MT_H:    return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [31:0]        rf [32];
  logic [31:0]        pc_p0, pc_p1, inst_p1, pc_p2, inst_p2, pc_p3, inst_p3;
  logic signed [31:0] rs1_p2, rs2_p2, alu_p3, rs2_p3;
  logic [4:0]         wbaddr_p4;
  logic [31:0]        wbdata_p4;
  logic               lb_valid;
  logic [31:0]        lb_addr, lb_data;
  ctrl_t              ctl_p1, ctl_p2, ctl_p3;

  assign ctl_p1 = decode(inst_p1);
  assign ctl_p2 = decode(inst_p2);
  assign ctl_p3 = decode(inst_p3);

  // DEC: register read, forwarding (EXE > MEM > WB) and load-use detection
  logic [4:0]         rs1_addr, rs2_addr;
  logic [31:0]        rf_rs1, rf_rs2;
  logic signed [31:0] byp_rs1, byp_rs2, alu_out, mem_wbdata;
  logic               stall;

  assign rs1_addr = inst_p1[19:15];
  assign rs2_addr = inst_p1[24:20];
  assign rf_rs1   = (rs1_addr == 5'd0) ? 32'd0 : rf[rs1_addr];
  assign rf_rs2   = (rs2_addr == 5'd0) ? 32'd0 : rf[rs2_addr];

  always_comb begin
    byp_rs1 = rf_rs1;
    byp_rs2 = rf_rs2;
    if (rs1_addr != 5'd0) begin
      if (rs1_addr == ctl_p2.rd)      byp_rs1 = alu_out;
      else if (rs1_addr == ctl_p3.rd) byp_rs1 = mem_wbdata;
      else if (rs1_addr == wbaddr_p4) byp_rs1 = wbdata_p4;
    end
    if (rs2_addr != 5'd0) begin
      if (rs2_addr == ctl_p2.rd)      byp_rs2 = alu_out;
      else if (rs2_addr == ctl_p3.rd) byp_rs2 = mem_wbdata;
      else if (rs2_addr == wbaddr_p4) byp_rs2 = wbdata_p4;
    end
  end

  assign stall = ctl_p2.is_load && ctl_p2.rd != 5'd0 &&
                 ((ctl_p1.uses_rs1 && rs1_addr == ctl_p2.rd) ||
                  (ctl_p1.uses_rs2 && rs2_addr == ctl_p2.rd));

  // EXE: ALU, branch resolution and redirect
  logic signed [31:0] op1, op2;
  logic               br_cond, taken;
  logic [31:0]        target;

  assign op1 = ctl_p2.op1_pc ? $signed(pc_p2) : rs1_p2;

  always_comb begin
    op2 = ctl_p2.imm;
    case (ctl_p2.op2_sel)
      OP2_RS2:  op2 = rs2_p2;
      OP2_FOUR: op2 = 32'sd4;
      default:  ;
    endcase
  end

  sodor5_alu u_alu (
    .alu_fun (ctl_p2.alu_fun),
    .op1     (op1),
    .op2     (op2),
    .result  (alu_out)
  );

  always_comb begin
    case (inst_p2[14:12])
      3'd0:    br_cond = rs1_p2 == rs2_p2;
      3'd1:    br_cond = rs1_p2 != rs2_p2;
      3'd4:    br_cond = rs1_p2 < rs2_p2;
      3'd5:    br_cond = rs1_p2 >= rs2_p2;
      3'd6:    br_cond = $unsigned(rs1_p2) < $unsigned(rs2_p2);
      3'd7:    br_cond = $unsigned(rs1_p2) >= $unsigned(rs2_p2);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken  = (ctl_p2.is_br && br_cond) || ctl_p2.is_jal || ctl_p2.is_jalr;
  assign target = ctl_p2.is_jalr ? ((rs1_p2 + ctl_p2.imm) & ~32'd1) : (pc_p2 + ctl_p2.imm);

  // MEM: load-buffer lookup
  logic        lb_hit;
  logic [31:0] mem_word;

  assign lb_hit     = lb_valid && lb_addr == alu_p3;
  assign mem_word   = lb_hit ? lb_data : 32'd0;
  assign mem_wbdata = ctl_p3.is_load ? load_ext(ctl_p3.mem_typ, mem_word) : alu_p3;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0     <= RESET_PC;
      pc_p1     <= '0;
      inst_p1   <= NOP;
      pc_p2     <= '0;
      inst_p2   <= NOP;
      pc_p3     <= '0;
      inst_p3   <= NOP;
      wbaddr_p4 <= '0;
      lb_valid  <= 1'b0;
      lb_addr   <= '0;
      lb_data   <= '0;
    end else begin
      if (taken)       pc_p0 <= target;
      else if (!stall) pc_p0 <= pc_p0 + 32'd4;
      if (!stall) begin
        pc_p1   <= pc_p0;
        inst_p1 <= taken ? NOP : fe_in_io_imem_resp_bits_data;
      end
      pc_p2     <= pc_p1;
      inst_p2   <= (stall || taken) ? NOP : inst_p1;
      pc_p3     <= pc_p2;
      inst_p3   <= inst_p2;
      wbaddr_p4 <= ctl_p3.rd;
      if (ctl_p3.is_load) begin
        lb_valid <= 1'b1;
        lb_addr  <= alu_p3;
        lb_data  <= mem_word;
      end else if (ctl_p3.is_store && lb_hit) begin
        lb_data  <= rs2_p3 & store_mask(ctl_p3.mem_typ);
      end
    end
  end

  // WB: datapath registers carry no reset; writes are gated by reset and wbaddr
  always_ff @(posedge clock) begin
    rs1_p2    <= byp_rs1;
    rs2_p2    <= byp_rs2;
    alu_p3    <= alu_out;
    rs2_p3    <= rs2_p2;
    wbdata_p4 <= mem_wbdata;
    if (!reset && wbaddr_p4 != 5'd0) rf[wbaddr_p4] <= wbdata_p4;
  end

  always_comb begin
    port_regfile = '0;
    for (int n = 1; n < 32; n++) port_regfile[32*n +: 32] = rf[n];
  end

  assign fe_ou_io_imem_req_bits_addr = pc_p0;
  assign fe_ou_io_imem_req_valid     = !reset;
  assign port_if_reg_pc        = pc_p0;
  assign port_dec_reg_pc       = pc_p1;
  assign port_exe_reg_pc       = pc_p2;
  assign port_mem_reg_pc       = pc_p3;
  assign port_dec_reg_inst     = inst_p1;
  assign port_exe_reg_inst     = inst_p2;
  assign port_mem_reg_inst     = inst_p3;
  assign port_imm              = imm_i(inst_p1);
  assign port_imm_sbtype_sext  = imm_b(inst_p1);
  assign port_reg_rs1_addr_in  = rs1_addr;
  assign port_reg_rs2_addr_in  = rs2_addr;
  assign port_reg_rs1_data_out = rf_rs1;
  assign port_reg_rs2_data_out = rf_rs2;
  assign port_reg_rd_addr_in   = wbaddr_p4;
  assign port_reg_rd_data_in   = wbdata_p4;
  assign port_dec_wbaddr       = inst_p1[11:7];
  assign port_exe_reg_wbaddr   = ctl_p2.rd;
  assign port_mem_reg_wbaddr   = ctl_p3.rd;
  assign port_alu_out          = alu_out;
  assign port_mem_reg_alu_out  = alu_p3;
  assign port_alu_fun          = ctl_p1.alu_fun;
  assign port_mem_fcn          = ctl_p1.mem_fcn;
  assign port_mem_typ          = ctl_p1.mem_typ;
  assign port_lb_table_valid   = lb_valid;
  assign port_lb_table_addr    = lb_addr;
  assign port_lb_table_data    = lb_data;

endmodule

// File: tb/tb_sodor5_core.sv
// Directed program bench for sodor5_core: fetch sequence, bypass, stall, flush, load buffer, reset.
module tb_sodor5_core;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   imem_data, req_addr;
  logic          req_valid;
  logic [1023:0] regfile;
  logic [31:0]   if_pc, dec_pc, exe_pc, mem_pc, dec_inst, exe_inst, mem_inst;
  logic [31:0]   imm, imm_sb, rs1_data, rs2_data, rd_data, alu_out, mem_alu_out;
  logic [4:0]    rs1_addr, rs2_addr, rd_addr, dec_wbaddr, exe_wbaddr, mem_wbaddr;
  logic [3:0]    alu_fun;
  logic          mem_fcn;
  logic [2:0]    mem_typ;
  logic          lb_valid;
  logic [31:0]   lb_addr, lb_data;

  logic [31:0]   rom [64];
  logic [31:0]   exp_pc [22];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clock = ~clock;

  assign imem_data = (req_addr < 32'd256) ? rom[req_addr[7:2]] : NOP_I;

  sodor5_core dut (
    .clock                        (clock),
    .reset                        (reset),
    .fe_in_io_imem_resp_bits_data (imem_data),
    .fe_ou_io_imem_req_bits_addr  (req_addr),
    .fe_ou_io_imem_req_valid      (req_valid),
    .port_regfile                 (regfile),
    .port_if_reg_pc               (if_pc),
    .port_dec_reg_pc              (dec_pc),
    .port_exe_reg_pc              (exe_pc),
    .port_mem_reg_pc              (mem_pc),
    .port_dec_reg_inst            (dec_inst),
    .port_exe_reg_inst            (exe_inst),
    .port_mem_reg_inst            (mem_inst),
    .port_imm                     (imm),
    .port_imm_sbtype_sext         (imm_sb),
    .port_reg_rs1_addr_in         (rs1_addr),
    .port_reg_rs2_addr_in         (rs2_addr),
    .port_reg_rs1_data_out        (rs1_data),
    .port_reg_rs2_data_out        (rs2_data),
    .port_reg_rd_addr_in          (rd_addr),
    .port_reg_rd_data_in          (rd_data),
    .port_dec_wbaddr              (dec_wbaddr),
    .port_exe_reg_wbaddr          (exe_wbaddr),
    .port_mem_reg_wbaddr          (mem_wbaddr),
    .port_alu_out                 (alu_out),
    .port_mem_reg_alu_out         (mem_alu_out),
    .port_alu_fun                 (alu_fun),
    .port_mem_fcn                 (mem_fcn),
    .port_mem_typ                 (mem_typ),
    .port_lb_table_valid          (lb_valid),
    .port_lb_table_addr           (lb_addr),
    .port_lb_table_data           (lb_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xreg(input int n);
    return regfile[32*n +: 32];
  endfunction

  task automatic check_reset_state();
    check("rst_valid", {31'b0, req_valid}, 32'd0);
    check("rst_pc", req_addr, 32'd0);
    check("rst_dec_inst", dec_inst, NOP_I);
    check("rst_exe_inst", exe_inst, NOP_I);
    check("rst_mem_inst", mem_inst, NOP_I);
    check("rst_exe_pc", exe_pc, 32'd0);
    check("rst_mem_wbaddr", {27'b0, mem_wbaddr}, 32'd0);
    check("rst_rd_addr", {27'b0, rd_addr}, 32'd0);
    check("rst_lb_valid", {31'b0, lb_valid}, 32'd0);
    check("rst_lb_addr", lb_addr, 32'd0);
    check("rst_lb_data", lb_data, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = NOP_I;
    rom[0]  = 32'h0030_0393; // addi x7,x0,3
    rom[1]  = 32'h0640_2083; // lw   x1,100(x0)
    rom[2]  = 32'h0090_0513; // addi x10,x0,9
    rom[3]  = 32'h0050_0113; // addi x2,x0,5
    rom[4]  = 32'h0021_01B3; // add  x3,x2,x2
    rom[5]  = 32'h0030_2223; // sw   x3,4(x0)
    rom[6]  = 32'h0640_0293; // addi x5,x0,100
    rom[7]  = 32'h0032_A023; // sw   x3,0(x5)
    rom[8]  = 32'h0640_2303; // lw   x6,100(x0)
    rom[9]  = 32'h0013_0213; // addi x4,x6,1
    rom[10] = 32'h0000_0463; // beq  x0,x0,+8
    rom[11] = 32'h0070_0393; // addi x7,x0,7
    rom[12] = 32'h0080_0413; // addi x8,x0,8
    rom[13] = 32'h0080_04EF; // jal  x9,+8
    rom[14] = 32'h0010_0513; // addi x10,x0,1
    rom[15] = 32'hFFF0_0593; // addi x11,x0,-1
    rom[16] = 32'h01C5_D613; // srli x12,x11,28
    rom[17] = 32'h1234_56B7; // lui  x13,0x12345
    rom[18] = 32'h4031_0733; // sub  x14,x2,x3
    exp_pc = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32,
               32'd36, 32'd40, 32'd40, 32'd44, 32'd48, 32'd48, 32'd52, 32'd56,
               32'd60, 32'd60, 32'd64, 32'd68, 32'd72};

    repeat (3) @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 31; c++) begin
      if (c < 22) check($sformatf("fetch_pc_c%0d", c), req_addr, exp_pc[c]);
      if (c == 0) check("fetch_valid", {31'b0, req_valid}, 32'd1);
      if (c == 4) check("lb_idle", {31'b0, lb_valid}, 32'd0);
      if (c == 5) begin
        check("lw_lb_valid", {31'b0, lb_valid}, 32'd1);
        check("lw_lb_addr", lb_addr, 32'd100);
        check("lw_lb_data", lb_data, 32'd0);
      end
      if (c == 6) begin
        check("x1_zero", xreg(1), 32'd0);
        check("add_exe_bypass", alu_out, 32'd10);
      end
      if (c == 9) begin
        check("x3_bypass", xreg(3), 32'd10);
        check("sw_miss_addr", lb_addr, 32'd100);
        check("sw_miss_data", lb_data, 32'd0);
      end
      if (c == 10) check("stall_dec_c10", dec_inst, 32'h0013_0213);
      if (c == 11) begin
        check("stall_dec_c11", dec_inst, 32'h0013_0213);
        check("stall_bubble", exe_inst, NOP_I);
        check("sw_hit_data", lb_data, 32'd10);
      end
      if (c == 12) begin
        check("load_use_alu", alu_out, 32'd11);
        check("lw_hit_data", lb_data, 32'd10);
        check("lw_hit_valid", {31'b0, lb_valid}, 32'd1);
      end
      if (c == 14) begin
        check("flush_dec", dec_inst, NOP_I);
        check("flush_exe", exe_inst, NOP_I);
        check("beq_in_mem", mem_inst, 32'h0000_0463);
      end
      if (c == 15) check("x4_load_use", xreg(4), 32'd11);
      if (c == 30) begin
        check("x0", xreg(0), 32'd0);
        check("x2", xreg(2), 32'd5);
        check("x5", xreg(5), 32'd100);
        check("x6_load", xreg(6), 32'd10);
        check("x7_flushed", xreg(7), 32'd3);
        check("x8_target", xreg(8), 32'd8);
        check("x9_link", xreg(9), 32'd56);
        check("x10_flushed", xreg(10), 32'd9);
        check("x11_neg", xreg(11), 32'hFFFF_FFFF);
        check("x12_srli", xreg(12), 32'h0000_000F);
        check("x13_lui", xreg(13), 32'h1234_5000);
        check("x14_sub", xreg(14), 32'hFFFF_FFFB);
      end
      @(negedge clock);
      #1;
    end

    reset = 1'b1;
    @(negedge clock);
    check_reset_state();
    reset = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("rerun_pc_c%0d", c), req_addr, exp_pc[c]);
      @(negedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    check("midrst_valid", {31'b0, req_valid}, 32'd0);
    @(negedge clock);
    check_reset_state();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sodor5_core.md
# sodor5_core

Five-stage (IF/DEC/EXE/MEM/WB) in-order RV32I integer core with a single-entry load-buffer table (lb_table) standing in for data memory. It fetches from a combinational instruction ROM and exposes register-file, pipeline and lb_table state on debug ports. Those ports feed two-copy non-interference checks (address-only lb_table divergence, pipeline equality) in the security verification environment.

## Interface
- No parameters. Reset PC = 0x00000000; NOP = 0x00000013.
- One clock; reset is synchronous and active-high. Port names are `clock` and `reset`.
- clock in 1: rising-edge clock.
- reset in 1: clears pipeline, PC and lb_table.
- fe_in_io_imem_resp_bits_data in 32: instruction at current fetch address, same cycle.
- fe_ou_io_imem_req_bits_addr out 32: fetch PC (if_reg_pc).
- fe_ou_io_imem_req_valid out 1: 1 when not in reset.
- port_regfile out 1024: x[n] at bits [32n+31:32n]; x0 reads 0.
- port_if_reg_pc / port_dec_reg_pc / port_exe_reg_pc / port_mem_reg_pc out 32 each: stage PCs.
- port_dec_reg_inst / port_exe_reg_inst / port_mem_reg_inst out 32 each: stage instructions; bubble = NOP.
- port_imm out 32: DEC I-type immediate, sign-extended.
- port_imm_sbtype_sext out 32: DEC B-type immediate, sign-extended.
- port_reg_rs1_addr_in / port_reg_rs2_addr_in out 5 each: DEC rs1/rs2 fields.
- port_reg_rs1_data_out / port_reg_rs2_data_out out 32 each: raw regfile read data, pre-bypass.
- port_reg_rd_addr_in out 5: WB write address; 0 if no write.
- port_reg_rd_data_in out 32: WB write data.
- port_dec_wbaddr out 5: DEC rd field.
- port_exe_reg_wbaddr / port_mem_reg_wbaddr out 5 each: rd of EXE/MEM instruction; 0 if no write.
- port_alu_out out 32: EXE ALU result.
- port_mem_reg_alu_out out 32: MEM-stage ALU result / address.
- port_alu_fun out 4: DEC ALU code. ADD0 SUB1 SLL2 SRL3 SRA4 AND5 OR6 XOR7 SLT8 SLTU9 COPY2_10.
- port_mem_fcn out 1: DEC memory function; 0 load, 1 store.
- port_mem_typ out 3: DEC memory type. none0 B1 H2 W3 BU5 HU6.
- port_lb_table_valid out 1, port_lb_table_addr out 32, port_lb_table_data out 32: load-buffer entry.

## Operation
- Supported: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, OP-IMM, OP.
- Any other encoding (FENCE, SYSTEM, illegal) executes as NOP.
- Register file: 32×32. Write in WB; x0 writes are ignored. Contents are not affected by reset.
- Bypassing: full forwarding into DEC operands from EXE, MEM and WB, in priority EXE > MEM > WB. Never forward from x0.
- Load-use hazard: 1-cycle stall. IF and DEC hold; a bubble is inserted into EXE.
- Branches and JAL/JALR resolve in EXE. When taken, redirect the PC and flush IF and DEC to bubbles.
- Load (MEM stage):
  - Address is mem_reg_alu_out.
  - Data is lb_table_data when valid and the address matches exactly; otherwise 0.
  - Extend data per mem_typ.
  - Next cycle: valid=1, addr=address, data=returned word.
- Store (MEM stage): on valid entry with exact address match, replace data with rs2 data masked per mem_typ. Otherwise lb_table is unchanged.
- Arithmetic: 32-bit wraparound. Shifts use the low 5 bits of the shift operand.

## Timing
- Reset:
  - PC=0; fetch valid=0.
  - All stage instruction registers = NOP; stage PCs = 0.
  - wbaddr ports = 0.
  - lb_table valid=0, addr=0, data=0.
- First fetch: address 0, on the cycle after reset deasserts.
- Instruction fetched at cycle t sits in DEC at t+1, EXE at t+2, MEM at t+3, and writes back at the end of t+4.
- lb_table update is visible on the ports at t+4.
- Regfile write is visible on port_regfile at t+5.
- Reset asserted mid-operation: all in-flight instructions are discarded; no writeback occurs in that cycle.

## Structure
- Shared package `sodor5_pkg`:
  - opcode constants;
  - alu_fun and mem_typ encodings;
  - NOP and reset-PC constants.
- One natural sub-module: `sodor5_alu`, a combinational 32-bit ALU driven by alu_fun.
- Regfile, hazard logic and lb_table stay inline in the core.

## Test plan
- Reset, then fetch NOPs: req_addr = 0, 4, 8… one per cycle; lb_table_valid stays 0.
- Fetch `lw x1,100(x0)` at PC 4: four cycles after its fetch, lb_table valid=1, addr=100, data=0; x1=0 written.
- `sw x1,4(x0)` to a non-matching address: lb_table is unchanged.
- A store that hits lb_table_addr updates lb_table_data; a later load to that address returns it.
- `addi x2,x0,5` then `add x3,x2,x2` back-to-back: x3=10 via bypass, no stall.
- `lw x1,…` followed by `addi x4,x1,1`: 1-cycle stall, with NOP visible in port_exe_reg_inst.
- Taken `beq x0,x0,+8`: the two younger instructions are flushed and the fetch address jumps to branch PC+8.
